// File: rtl/seq_add_pkg.sv
// Shared types and helpers for the chunked sequential adder: FSM state encoding
// and the width helper used to size the chunk counter.
package seq_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1, so a single-chunk build still gets a
    // legal one-bit counter instead of a zero-width vector.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder: (x, y, ci) -> (s, co).
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    // NOTE: every bit of s and c is assigned on every pass, so no latch is inferred.
    always_comb begin
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder adding CHUNK bits per clock with a registered carry,
// returning {carry_out, sum}. Optional signed-overflow flag under SEQ_ADD_OVF_EN.
module chunked_seq_adder
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             busy
`ifdef SEQ_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N_CHUNKS = WIDTH / CHUNK;
    localparam int CNT_W    = clog2_min1(N_CHUNKS);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("chunked_seq_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   sum_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             ovf_q;

    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] y_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
    logic             last_chunk;

    // One adder slice, fed the operand chunk currently selected by the counter.
    always_comb begin
        x_chunk = a_q[cnt_q*CHUNK +: CHUNK];
        y_chunk = b_q[cnt_q*CHUNK +: CHUNK];
    end

    assign last_chunk = (cnt_q == CNT_W'(N_CHUNKS - 1));

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .x  (x_chunk),
        .y  (y_chunk),
        .ci (carry_q),
        .s  (s_chunk),
        .co (co_chunk)
    );

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        sum_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    sum_q[cnt_q*CHUNK +: CHUNK] <= s_chunk;
                    carry_q                     <= co_chunk;
                    if (last_chunk) begin
                        sum_q[WIDTH] <= co_chunk;
                        out_valid_q  <= 1'b1;
                        // Top chunk's MSB is the final sum[WIDTH-1] being written this edge.
                        ovf_q        <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                        (s_chunk[CHUNK-1] != a_q[WIDTH-1]);
                        state        <= ST_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        ovf_q       <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                    ovf_q       <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign busy      = busy_q;

`ifdef SEQ_ADD_OVF_EN
    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule
